sc_speed_scheduler: RTL and testbench



---
 rtl/sc_speed_scheduler_if.sv | 29 ++
 rtl/sc_speed_scheduler.sv | 137 +++++++++++++
 tb/tb_sc_speed_scheduler.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/sc_speed_scheduler_if.sv
// Command/status bundle between the movement logic (master) and the speed scheduler (slave).
// SC_SPEEDCTRL_TURBO_EN adds the turbo command line.
interface sc_speed_scheduler_if;
    logic       SC_SPEEDCTRL_accel_InLow;
    logic       SC_SPEEDCTRL_brake_InLow;
    logic       SC_SPEEDCTRL_crash_InLow;
`ifdef SC_SPEEDCTRL_TURBO_EN
    logic       SC_SPEEDCTRL_turbo_InLow;
`endif
    logic       SC_SPEEDCTRL_tick_OutLow;
    logic [1:0] SC_SPEEDCTRL_level_Out;
    logic       SC_SPEEDCTRL_crash_OutLow;

    modport master (
        output SC_SPEEDCTRL_accel_InLow, SC_SPEEDCTRL_brake_InLow, SC_SPEEDCTRL_crash_InLow,
`ifdef SC_SPEEDCTRL_TURBO_EN
        output SC_SPEEDCTRL_turbo_InLow,
`endif
        input  SC_SPEEDCTRL_tick_OutLow, SC_SPEEDCTRL_level_Out, SC_SPEEDCTRL_crash_OutLow
    );

    modport slave (
        input  SC_SPEEDCTRL_accel_InLow, SC_SPEEDCTRL_brake_InLow, SC_SPEEDCTRL_crash_InLow,
`ifdef SC_SPEEDCTRL_TURBO_EN
        input  SC_SPEEDCTRL_turbo_InLow,
`endif
        output SC_SPEEDCTRL_tick_OutLow, SC_SPEEDCTRL_level_Out, SC_SPEEDCTRL_crash_OutLow
    );
endinterface

// File: rtl/sc_speed_scheduler.sv
// Player-car speed scheduler: speed level 0..3 from held commands, level-paced move tick, crash stall.
// Optional SC_SPEEDCTRL_TURBO_EN halves the level-3 tick period while turbo is held low.
module sc_speed_scheduler #(
    parameter int unsigned           TICK_WIDTH  = 26,
    parameter logic [TICK_WIDTH-1:0] PERIOD1     = 26'd12_500_000,
    parameter logic [TICK_WIDTH-1:0] PERIOD2     = 26'd6_250_000,
    parameter logic [TICK_WIDTH-1:0] PERIOD3     = 26'd3_125_000,
    parameter logic [TICK_WIDTH-1:0] DWELL       = 26'd25_000_000,
    parameter logic [TICK_WIDTH-1:0] CRASH_STALL = 26'd50_000_000
) (
    input  logic                SC_SPEEDCTRL_CLOCK_50,
    input  logic                SC_SPEEDCTRL_RESET_InLow,
    sc_speed_scheduler_if.slave ctrl
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CRASH} state_e;
    typedef enum logic [1:0] {CMD_NONE, CMD_ACCEL, CMD_BRAKE} cmd_e;

    localparam logic [TICK_WIDTH-1:0] ONE = TICK_WIDTH'(1);

    state_e                state_q, state_d;
    cmd_e                  cmd_q, cmd_d, cmd;
    logic [1:0]            level_q, level_d;
    logic [TICK_WIDTH-1:0] tick_cnt_q, tick_cnt_d;
    logic [TICK_WIDTH-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [TICK_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic                  tick_n_q, tick_n_d;
    logic                  crash_n_q, crash_n_d;
    logic [TICK_WIDTH-1:0] period, dwell_base;
    logic                  crash_hit, turbo_on, turbo_toggle, tick_hit;

    assign crash_hit = ~ctrl.SC_SPEEDCTRL_crash_InLow;
    assign cmd       = ~ctrl.SC_SPEEDCTRL_brake_InLow ? CMD_BRAKE :
                       ~ctrl.SC_SPEEDCTRL_accel_InLow ? CMD_ACCEL : CMD_NONE;
    // A newly resolved command starts its dwell from zero on this very edge.
    assign dwell_base = (cmd != cmd_q) ? '0 : dwell_cnt_q;

`ifdef SC_SPEEDCTRL_TURBO_EN
    logic turbo_q;
    assign turbo_on     = ~ctrl.SC_SPEEDCTRL_turbo_InLow;
    assign turbo_toggle = (turbo_q != ctrl.SC_SPEEDCTRL_turbo_InLow) &&
                          (state_q == S_RUN) && (level_q == 2'd3);
    always_ff @(posedge SC_SPEEDCTRL_CLOCK_50 or negedge SC_SPEEDCTRL_RESET_InLow)
        if (!SC_SPEEDCTRL_RESET_InLow) turbo_q <= 1'b1;
        else                           turbo_q <= ctrl.SC_SPEEDCTRL_turbo_InLow;
`else
    assign turbo_on     = 1'b0;
    assign turbo_toggle = 1'b0;
`endif

    always_comb begin
        period = PERIOD1;
        case (level_q)
            2'd2:    period = PERIOD2;
            2'd3:    period = turbo_on ? (PERIOD3 >> 1) : PERIOD3;
            default: period = PERIOD1;
        endcase
    end

    // State register (plus the datapath registers it sequences).
    always_ff @(posedge SC_SPEEDCTRL_CLOCK_50 or negedge SC_SPEEDCTRL_RESET_InLow) begin
        if (!SC_SPEEDCTRL_RESET_InLow) begin
            state_q     <= S_IDLE;
            cmd_q       <= CMD_NONE;
            level_q     <= 2'd0;
            tick_cnt_q  <= '0;
            dwell_cnt_q <= '0;
            stall_cnt_q <= '0;
            tick_n_q    <= 1'b1;
            crash_n_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            level_q     <= level_d;
            tick_cnt_q  <= tick_cnt_d;
            dwell_cnt_q <= dwell_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            tick_n_q    <= tick_n_d;
            crash_n_q   <= crash_n_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd;
        level_d     = level_q;
        tick_cnt_d  = tick_cnt_q;
        dwell_cnt_d = dwell_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (crash_hit) begin
            state_d     = S_CRASH;
            cmd_d       = CMD_NONE;
            level_d     = 2'd0;
            tick_cnt_d  = '0;
            dwell_cnt_d = '0;
            stall_cnt_d = '0;
        end else if (state_q == S_CRASH) begin
            cmd_d = CMD_NONE;
            if (stall_cnt_q == CRASH_STALL - ONE) begin
                state_d     = S_IDLE;
                stall_cnt_d = '0;
            end else begin
                stall_cnt_d = stall_cnt_q + ONE;
            end
        end else begin
            if (cmd == CMD_NONE) begin
                dwell_cnt_d = '0;
            end else if (dwell_base == DWELL - ONE) begin
                dwell_cnt_d = '0;
                if (cmd == CMD_ACCEL && level_q != 2'd3) level_d = level_q + 2'd1;
                if (cmd == CMD_BRAKE && level_q != 2'd0) level_d = level_q - 2'd1;
            end else begin
                dwell_cnt_d = dwell_base + ONE;
            end
            state_d = (level_d == 2'd0) ? S_IDLE : S_RUN;
            // Level or turbo change restarts the period without firing.
            if (state_d != S_RUN || level_d != level_q || turbo_toggle)
                tick_cnt_d = '0;
            else if (tick_cnt_q == period - ONE)
                tick_cnt_d = '0;
            else
                tick_cnt_d = tick_cnt_q + ONE;
        end
    end

    // Output logic (registered by the state register process).
    always_comb begin
        tick_hit  = !crash_hit && (state_q == S_RUN) && (level_d == level_q) &&
                    !turbo_toggle && (tick_cnt_q == period - ONE);
        tick_n_d  = ~tick_hit;
        crash_n_d = (state_d != S_CRASH);
    end

    assign ctrl.SC_SPEEDCTRL_tick_OutLow  = tick_n_q;
    assign ctrl.SC_SPEEDCTRL_level_Out    = level_q;
    assign ctrl.SC_SPEEDCTRL_crash_OutLow = crash_n_q;
endmodule

// File: tb/tb_sc_speed_scheduler.sv
// Directed bench for sc_speed_scheduler with short periods; cycle trace table plus hand sequences.
module tb_sc_speed_scheduler;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sc_speed_scheduler_if bus();

    sc_speed_scheduler #(
        .TICK_WIDTH (26),
        .PERIOD1    (26'd8),
        .PERIOD2    (26'd4),
        .PERIOD3    (26'd2),
        .DWELL      (26'd4),
        .CRASH_STALL(26'd10)
    ) dut (
        .SC_SPEEDCTRL_CLOCK_50   (clk),
        .SC_SPEEDCTRL_RESET_InLow(rst_n),
        .ctrl                    (bus)
    );

    typedef struct {
        logic       a, b, c;
        logic [1:0] lvl;
        logic       t, cr;
    } vec_t;

    vec_t vq[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic vr(input int n, input int a, input int b, input int c,
                      input int l, input int t, input int cr);
        repeat (n) begin
            vec_t r;
            r.a = 1'(a); r.b = 1'(b); r.c = 1'(c);
            r.lvl = 2'(l); r.t = 1'(t); r.cr = 1'(cr);
            vq.push_back(r);
        end
    endtask

    task automatic drive(input logic a, input logic b, input logic c);
        bus.SC_SPEEDCTRL_accel_InLow = a;
        bus.SC_SPEEDCTRL_brake_InLow = b;
        bus.SC_SPEEDCTRL_crash_InLow = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lows;
        bit found;
        // Cycle trace: {accel, brake, crash} applied, then {level, tick, crash_out} after the edge.
        vr(3,0,1,1,0,1,1); vr(1,0,1,1,1,1,1);                       // accel 4 clk -> level 1
        vr(3,0,1,1,1,1,1); vr(1,0,1,1,2,1,1);                       // -> level 2
        vr(3,0,1,1,2,1,1); vr(1,0,1,1,3,1,1);                       // -> level 3, no tick on change
        vr(1,0,1,1,3,1,1); vr(1,0,1,1,3,0,1); vr(1,0,1,1,3,1,1);    // period 2, saturated at 3
        vr(1,0,1,1,3,0,1); vr(1,0,1,1,3,1,1); vr(1,0,1,1,3,0,1);
        vr(1,1,1,1,3,1,1); vr(1,1,1,1,3,0,1);                       // release
        vr(1,1,0,1,3,1,1); vr(1,1,0,1,3,0,1); vr(1,1,0,1,3,1,1);    // brake -> level 2
        vr(1,1,0,1,2,1,1);
        vr(3,1,1,1,2,1,1); vr(1,1,1,1,2,0,1);                       // period 4
        vr(3,0,0,1,2,1,1); vr(1,0,0,1,1,1,1);                       // both low: brake wins
        vr(7,1,1,1,1,1,1); vr(1,1,1,1,1,0,1); vr(1,1,1,1,1,1,1);    // period 8
        vr(3,0,1,1,1,1,1); vr(1,1,1,1,1,1,1);                       // release after 3 clears dwell
        vr(2,0,1,1,1,1,1); vr(1,0,1,1,1,0,1); vr(1,0,1,1,2,1,1);
        vr(3,1,0,1,2,1,1); vr(1,1,0,1,1,1,1);                       // tick due on change edge is dropped
        vr(3,1,0,1,1,1,1); vr(1,1,0,1,0,1,1);                       // -> IDLE
        vr(3,1,1,1,0,1,1);
        vr(3,0,1,1,0,1,1); vr(4,0,1,1,1,1,1); vr(4,0,1,1,2,1,1);    // ramp back to 3
        vr(1,0,1,1,3,1,1);
        vr(1,0,1,0,0,1,0); vr(9,0,1,1,0,1,0); vr(1,0,1,1,0,1,1);    // crash, 10 clk stall, accel ignored
        vr(3,0,1,1,0,1,1); vr(1,0,1,1,1,1,1);                       // accel counts fresh after crash

        drive(1'b1, 1'b1, 1'b1);
`ifdef SC_SPEEDCTRL_TURBO_EN
        bus.SC_SPEEDCTRL_turbo_InLow = 1'b1;
`endif
        rst_n = 1'b0;
        repeat (3) step();
        chk("reset level", int'(bus.SC_SPEEDCTRL_level_Out), 0);
        chk("reset tick", int'(bus.SC_SPEEDCTRL_tick_OutLow), 1);
        chk("reset crash", int'(bus.SC_SPEEDCTRL_crash_OutLow), 1);
        rst_n = 1'b1;

        lows = 0;
        repeat (20) begin
            step();
            if (!bus.SC_SPEEDCTRL_tick_OutLow) lows++;
        end
        chk("idle tick lows", lows, 0);
        chk("idle level", int'(bus.SC_SPEEDCTRL_level_Out), 0);
        chk("idle crash", int'(bus.SC_SPEEDCTRL_crash_OutLow), 1);

        foreach (vq[i]) begin
            drive(vq[i].a, vq[i].b, vq[i].c);
            step();
            chk($sformatf("vec%0d level", i), int'(bus.SC_SPEEDCTRL_level_Out), int'(vq[i].lvl));
            chk($sformatf("vec%0d tick", i), int'(bus.SC_SPEEDCTRL_tick_OutLow), int'(vq[i].t));
            chk($sformatf("vec%0d crash", i), int'(bus.SC_SPEEDCTRL_crash_OutLow), int'(vq[i].cr));
        end

        // Crash re-strobed mid-stall restarts the 10-clk count.
        drive(1'b1, 1'b1, 1'b0); step();
        chk("crash1 out", int'(bus.SC_SPEEDCTRL_crash_OutLow), 0);
        chk("crash1 level", int'(bus.SC_SPEEDCTRL_level_Out), 0);
        drive(1'b1, 1'b1, 1'b1); repeat (5) step();
        drive(1'b1, 1'b1, 1'b0); step();
        drive(1'b1, 1'b1, 1'b1);
        lows = 0;
        repeat (9) begin
            step();
            if (!bus.SC_SPEEDCTRL_crash_OutLow) lows++;
        end
        chk("restart stall low clks", lows, 9);
        step();
        chk("restart stall end", int'(bus.SC_SPEEDCTRL_crash_OutLow), 1);

        drive(1'b0, 1'b1, 1'b1); repeat (12) step();
        chk("ramp2 level", int'(bus.SC_SPEEDCTRL_level_Out), 3);
        drive(1'b1, 1'b1, 1'b1);

`ifdef SC_SPEEDCTRL_TURBO_EN
        step(); // counter now 1 at period 2
        bus.SC_SPEEDCTRL_turbo_InLow = 1'b0; step();
        chk("turbo press edge tick", int'(bus.SC_SPEEDCTRL_tick_OutLow), 1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("turbo tick %0d", k), int'(bus.SC_SPEEDCTRL_tick_OutLow), 0);
        end
        bus.SC_SPEEDCTRL_turbo_InLow = 1'b1; step();
        chk("turbo release edge", int'(bus.SC_SPEEDCTRL_tick_OutLow), 1);
        step(); chk("turbo release +1", int'(bus.SC_SPEEDCTRL_tick_OutLow), 1);
        step(); chk("turbo release +2", int'(bus.SC_SPEEDCTRL_tick_OutLow), 0);
        step(); chk("turbo release +3", int'(bus.SC_SPEEDCTRL_tick_OutLow), 1);
`endif

        // Async reset while a tick is low at level 3.
        found = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            step();
            if (!bus.SC_SPEEDCTRL_tick_OutLow) found = 1'b1;
        end
        chk("tick found before async reset", int'(found), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst level", int'(bus.SC_SPEEDCTRL_level_Out), 0);
        chk("async rst tick", int'(bus.SC_SPEEDCTRL_tick_OutLow), 1);
        chk("async rst crash", int'(bus.SC_SPEEDCTRL_crash_OutLow), 1);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) step();
        chk("post rst level", int'(bus.SC_SPEEDCTRL_level_Out), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
